// File: rtl/tcp_checksum_inserter_if.sv
// tcp_checksum_inserter_if
//   Bundles the two sides of the checksum inserter.
//   Encoder side (into the inserter):
//     in_data, in_wr_en  : segment word and its write strobe
//     in_fin             : level, held high once the segment is complete
//     in_checksum, in_len: final checksum and byte length, valid while in_fin is high
//   Stream side (out of the inserter):
//     out_data, out_valid, out_last, out_len, and out_ready back from the consumer
//
//   Handshake: a word moves when out_valid and out_ready are both high on a
//   rising clk edge. While out_valid is high and out_ready is low, out_data,
//   out_last and out_valid hold their values. out_valid never waits on out_ready.
//
//   Modports: slave = the inserter; master = the environment around it,
//   which drives the encoder-side signals and out_ready.
interface tcp_checksum_inserter_if;
  logic [31:0] in_data;
  logic        in_wr_en;
  logic        in_fin;
  logic [15:0] in_checksum;
  logic [15:0] in_len;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] out_len;

  modport slave (
    input  in_data, in_wr_en, in_fin, in_checksum, in_len, out_ready,
    output out_data, out_valid, out_last, out_len
  );

  modport master (
    output in_data, in_wr_en, in_fin, in_checksum, in_len, out_ready,
    input  out_data, out_valid, out_last, out_len
  );
endinterface

// File: rtl/tcp_checksum_inserter.sv
// tcp_checksum_inserter
//   Buffers one TCP segment from the segment encoder (checksum field zeroed),
//   latches the final checksum and length when the encoder raises in_fin,
//   then replays the segment with the checksum placed in the upper half of
//   header word 4.
//
// Parameters
//   DEPTH_LOG2 : buffer holds 2^DEPTH_LOG2 32-bit words
// Ports
//   clk       : single rising-edge clock
//   reset     : synchronous, active-high
//   bus       : tcp_checksum_inserter_if.slave (encoder input + output stream)
//   busy      : high in DRAIN and WAIT_CLR; encoder must not start a segment
//   drop      : one-cycle pulse when a segment is discarded
//   state_dbg : current FSM state (IDLE=0, CAPTURE=1, DRAIN=2, WAIT_CLR=3)
// Build option
//   TCP_LEN_CHECK_EN : when defined, a segment whose word count does not match
//                      (in_len+3)>>2 is discarded just like an overflow.
module tcp_checksum_inserter #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  tcp_checksum_inserter_if.slave        bus,
  output logic                          busy,
  output logic                          drop,
  output logic [1:0]                    state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] WC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    DRAIN    = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   wc;
  logic [DEPTH_LOG2-1:0] rp;
  logic                  ovf;
  logic                  rd_done;   // every word of the segment has been read
  logic [15:0]           csum_q;
  logic [15:0]           len_q;

  // Read stage: the synchronous RAM output register plus its tag.
  logic [31:0]           mem_q;
  logic                  s1_valid;
  logic [DEPTH_LOG2-1:0] s1_idx;

  // Output register.
  logic [31:0]           out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  drop_q;

  logic wr_fits, mem_we, ovf_eff, len_bad, drop_set, latch_fin;
  logic out_adv, rd_en, last_xfer, clr;
  logic [DEPTH_LOG2-1:0] mem_waddr;

  assign wr_fits   = (wc != WC_FULL);
  assign mem_we    = bus.in_wr_en &&
                     ((state == IDLE) || ((state == CAPTURE) && wr_fits));
  assign mem_waddr = (state == IDLE) ? '0 : wc[DEPTH_LOG2-1:0];
  // A word arriving in the same cycle as in_fin counts toward the segment,
  // so overflow and length decisions look at the post-write view.
  assign ovf_eff   = ovf || ((state == CAPTURE) && bus.in_wr_en && !wr_fits);

`ifdef TCP_LEN_CHECK_EN
  logic [DEPTH_LOG2:0] wc_eff;
  logic [16:0]         len_words;
  assign wc_eff    = mem_we ? wc + 1'b1 : wc;
  assign len_words = (17'(bus.in_len) + 17'd3) >> 2;
  assign len_bad   = (32'(wc_eff) != 32'(len_words));
`else
  assign len_bad   = 1'b0;
`endif

  // The output register can take a new word when it is empty or being
  // consumed. A RAM read is only issued when the read stage will be free at
  // the same edge, so mem_q is never overwritten while it still holds a word.
  assign out_adv   = !out_valid_q || bus.out_ready;
  assign rd_en     = (state == DRAIN) && !rd_done && (!s1_valid || out_adv);
  assign last_xfer = out_valid_q && bus.out_ready && out_last_q;
  assign clr       = (state == WAIT_CLR) && !bus.in_fin;

  always_comb begin
    state_nxt = state;
    drop_set  = 1'b0;
    latch_fin = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_wr_en) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (bus.in_fin) begin
          latch_fin = 1'b1;
          if (ovf_eff || len_bad) begin
            state_nxt = WAIT_CLR;
            drop_set  = 1'b1;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_xfer) state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        // Wait for the encoder to release in_fin so it cannot retrigger.
        if (!bus.in_fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Buffer RAM: single write port, registered read.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.in_data;
    if (rd_en)  mem_q <= mem[rp];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wc          <= '0;
      rp          <= '0;
      ovf         <= 1'b0;
      rd_done     <= 1'b0;
      csum_q      <= '0;
      len_q       <= '0;
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= drop_set;

      if (clr) begin
        wc      <= '0;
        rp      <= '0;
        ovf     <= 1'b0;
        rd_done <= 1'b0;
      end else begin
        if (state == IDLE && bus.in_wr_en) wc <= (DEPTH_LOG2 + 1)'(1);
        else if (state == CAPTURE && mem_we) wc <= wc + 1'b1;
        if (state == CAPTURE && bus.in_wr_en && !wr_fits) ovf <= 1'b1;
        if (rd_en) begin
          rp <= rp + 1'b1;
          if ((DEPTH_LOG2 + 1)'(rp) == wc - 1'b1) rd_done <= 1'b1;
        end
      end

      if (latch_fin) begin
        csum_q <= bus.in_checksum;
        len_q  <= bus.in_len;
      end

      if (rd_en) begin
        s1_valid <= 1'b1;
        s1_idx   <= rp;
      end else if (out_adv) begin
        s1_valid <= 1'b0;
      end

      if (out_adv) begin
        out_valid_q <= s1_valid;
        out_last_q  <= s1_valid && ((DEPTH_LOG2 + 1)'(s1_idx) == wc - 1'b1);
        if (s1_valid) begin
          // Header word 4 carries the checksum in its upper half.
          out_data_q <= (32'(s1_idx) == 32'd4) ? {csum_q, mem_q[15:0]} : mem_q;
        end
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_len   = len_q;
  assign busy          = (state == DRAIN) || (state == WAIT_CLR);
  assign drop          = drop_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_tcp_checksum_inserter.sv
// tb_tcp_checksum_inserter
//   Directed bench for tcp_checksum_inserter built with DEPTH_LOG2=3 (8-word
//   buffer) so the overflow case is reachable. Expected words come from the
//   stimulus table seg_w with the checksum placed in word 4's upper half.
module tb_tcp_checksum_inserter;
  localparam int DL2 = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic       drop;
  logic [1:0] state_dbg;

  tcp_checksum_inserter_if bus ();

  tcp_checksum_inserter #(.DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .drop      (drop),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] seg_w [16];
  bit          rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // All stimulus changes and all samples happen 1 ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = seg_w[i];
      bus.in_wr_en = 1'b1;
      step();
    end
    bus.in_wr_en = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic load_expected(input int n, input logic [15:0] csum);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 4) exp_q.push_back({csum, seg_w[i][15:0]});
      else        exp_q.push_back(seg_w[i]);
    end
  endtask

  // Consume the output stream until the out_last transfer. Every cycle with
  // out_valid is compared against the head of exp_q, so a word that changes
  // during a stall or a lost/duplicated word shows up as a data mismatch.
  task automatic drain(input string tag, input bit bp);
    int cyc  = 0;
    bit done = 1'b0;
    while (!done && cyc < 200) begin
      bus.out_ready = bp ? rdy_pat[cyc % 4] : 1'b1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_word"}, 32'(bus.out_valid), 32'd0);
          done = 1'b1;
        end else begin
          check({tag, "_data"}, bus.out_data, exp_q[0]);
          check({tag, "_last"}, 32'(bus.out_last), 32'(exp_q.size() == 1));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (bus.out_last) done = 1'b1;
          end
        end
      end
      step();
      cyc++;
    end
    bus.out_ready = 1'b1;
    check({tag, "_drain_done"}, 32'(done), 32'd1);
    check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Capture n words from seg_w, raise in_fin, check latency, drain, then
  // hold in_fin for 'hold' extra cycles before releasing it.
  task automatic run_seg(input string tag, input int n, input logic [15:0] csum,
                         input logic [15:0] len, input bit bp, input int hold);
    int lat  = 0;
    bit seen = 1'b0;
    load_expected(n, csum);
    send_words(n);
    bus.in_checksum = csum;
    bus.in_len      = len;
    bus.in_fin      = 1'b1;
    while (!bus.out_valid && lat < 20) begin
      step();
      lat++;
    end
    // Edges counted: the one sampling in_fin, the RAM read, the output register.
    check({tag, "_latency_edges"}, 32'(lat), 32'd3);
    check({tag, "_out_len"}, 32'(bus.out_len), 32'(len));
    check({tag, "_busy_drain"}, 32'(busy), 32'd1);
    check({tag, "_state_drain"}, 32'(state_dbg), 32'd2);
    drain(tag, bp);
    check({tag, "_valid_after_last"}, 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, "_no_redrain"}, 32'(seen), 32'd0);
    check({tag, "_busy_fin_held"}, 32'(busy), 32'd1);
    check({tag, "_out_len_held"}, 32'(bus.out_len), 32'(len));
    bus.in_fin = 1'b0;
    step();
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
  endtask

  // Capture n words, raise in_fin, expect exactly one drop pulse and no output.
  task automatic run_drop(input string tag, input int n, input logic [15:0] len);
    int drops = 0;
    bit seen  = 1'b0;
    send_words(n);
    bus.in_checksum = 16'h1234;
    bus.in_len      = len;
    bus.in_fin      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (drop) drops++;
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, "_drop_pulses"}, 32'(drops), 32'd1);
    check({tag, "_no_output"}, 32'(seen), 32'd0);
    check({tag, "_busy_wait"}, 32'(busy), 32'd1);
    check({tag, "_state_wait"}, 32'(state_dbg), 32'd3);
    bus.in_fin = 1'b0;
    step();
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int xfers;
    int cyc;
    reset           = 1'b1;
    bus.in_data     = '0;
    bus.in_wr_en    = 1'b0;
    bus.in_fin      = 1'b0;
    bus.in_checksum = '0;
    bus.in_len      = '0;
    bus.out_ready   = 1'b1;
    repeat (3) step();

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_out_data",  bus.out_data,       32'd0);
    check("rst_out_len",   32'(bus.out_len),   32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_drop",      32'(drop),          32'd0);
    check("rst_state",     32'(state_dbg),     32'd0);
    reset = 1'b0;
    step();

    // in_fin with nothing captured is ignored.
    bus.in_fin = 1'b1;
    repeat (3) step();
    check("idle_fin_state", 32'(state_dbg), 32'd0);
    check("idle_fin_busy",  32'(busy),      32'd0);
    bus.in_fin = 1'b0;
    step();

    // Header-only segment: word 4 becomes 0xBEEF0000.
    seg_w[0] = 32'h00501F90;
    seg_w[1] = 32'h00000001;
    seg_w[2] = 32'h00000002;
    seg_w[3] = 32'h50120400;
    seg_w[4] = 32'h00000000;
    run_seg("hdr", 5, 16'hBEEF, 16'd20, 1'b0, 0);

    // 8-word data segment (fills the buffer exactly) under backpressure.
    for (int i = 0; i < 8; i++) seg_w[i] = 32'h10000000 | (32'(i) * 32'h00110011);
    run_seg("bp", 8, 16'hCAFE, 16'd30, 1'b1, 0);

    // Overflow: 9 writes into an 8-word buffer.
    for (int i = 0; i < 9; i++) seg_w[i] = 32'hD0000000 + 32'(i);
    run_drop("ovf", 9, 16'd36);

    // Length mismatch: 6 words but in_len says 7.
    for (int i = 0; i < 6; i++) seg_w[i] = 32'h60000000 + (32'(i) << 8);
`ifdef TCP_LEN_CHECK_EN
    run_drop("len", 6, 16'd28);
`else
    run_seg("len", 6, 16'h7777, 16'd28, 1'b0, 0);
`endif

    // in_fin held for 10 cycles after out_last.
    for (int i = 0; i < 6; i++) seg_w[i] = 32'h0ABC0000 ^ (32'(i) * 32'h01010101);
    run_seg("hold", 6, 16'h0F0F, 16'd24, 1'b0, 10);

    // Reset while word 2 is on the output.
    for (int i = 0; i < 5; i++) seg_w[i] = 32'h77000000 + (32'(i) << 4);
    load_expected(5, 16'h5A5A);
    send_words(5);
    bus.in_checksum = 16'h5A5A;
    bus.in_len      = 16'd20;
    bus.in_fin      = 1'b1;
    xfers = 0;
    cyc   = 0;
    while (xfers < 2 && cyc < 50) begin
      if (bus.out_valid && bus.out_ready) xfers++;
      step();
      cyc++;
    end
    check("rstmid_word2", bus.out_data, seg_w[2]);
    reset      = 1'b1;
    bus.in_fin = 1'b0;
    step();
    reset = 1'b0;
    check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_busy",      32'(busy),          32'd0);
    check("rstmid_out_len",   32'(bus.out_len),   32'd0);
    check("rstmid_drop",      32'(drop),          32'd0);
    step();

    for (int i = 0; i < 5; i++) seg_w[i] = 32'h31000000 | (32'(i) << 12) | 32'h0000ABCD;
    run_seg("post_rst", 5, 16'h1357, 16'd20, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tcp_checksum_inserter.md
# tcp_checksum_inserter

Segment buffer directly downstream of the TCP segment encoder. It captures the encoder's 32-bit segment word stream, which has the checksum field zeroed. When the encoder signals completion, it latches the final checksum and segment length. It then replays the buffered segment on a valid/ready stream with the checksum patched into header word 4, so the IP encoder stage receives a wire-ready TCP segment.

## Interface
- `DEPTH_LOG2`, default 10. Buffer depth is 2^DEPTH_LOG2 32-bit words (4 KiB at default).
- `clk`, in, 1. Single clock. All logic is on its rising edge.
- `reset`, in, 1. Synchronous, active-high.
- `in_data`, in, 32. Segment word from the encoder (`pkg_data`).
- `in_wr_en`, in, 1. `in_data` is valid this cycle.
- `in_fin`, in, 1. Level signal. Held high by the encoder once the segment is complete.
- `in_checksum`, in, 16. Final TCP checksum. Valid while `in_fin` is high.
- `in_len`, in, 16. Segment length in bytes, header included. Valid while `in_fin` is high.
- `out_data`, out, 32. Segment word, with the checksum inserted.
- `out_valid`, out, 1. `out_data` is valid.
- `out_ready`, in, 1. The consumer accepts the word.
- `out_last`, out, 1. Final word of the segment. Qualified by `out_valid`.
- `out_len`, out, 16. Latched `in_len`. Stable from the first `out_valid` until the return to IDLE.
- `busy`, out, 1. High in DRAIN and WAIT_CLR. The upstream encoder must not be started while it is high.
- `drop`, out, 1. One-cycle pulse when a segment is discarded.

## Operation
- States are IDLE, CAPTURE, DRAIN and WAIT_CLR.
- IDLE:
  - `in_wr_en` writes `mem[0]`, sets word count `wc`=1 and moves to CAPTURE.
  - `in_fin` with no captured words is ignored.
- CAPTURE, on `in_wr_en`:
  - Writes `mem[wc]` and increments `wc`.
  - A write at `wc`=2^DEPTH_LOG2 is discarded and sets an internal `ovf` flag.
- CAPTURE, on the first `in_fin`=1:
  - Latches `in_checksum` and `in_len`.
  - If `ovf` is set: pulse `drop` and go to WAIT_CLR.
  - Otherwise go to DRAIN with the read pointer `rp`=0.
  - If `in_wr_en` and `in_fin` are high in the same cycle, the word is written first and is included in the segment.
- DRAIN:
  - Emits words `rp` = 0 .. `wc`-1.
  - The word at `rp`=4 is output as `{checksum_latched, mem[4][15:0]}`. Every other word is output as stored.
  - `out_last`=1 on `rp`=`wc`-1.
  - After the last accepted transfer, go to WAIT_CLR.
- WAIT_CLR:
  - Stays until `in_fin`=0, then goes to IDLE and clears `wc`, `rp` and `ovf`.
  - This prevents the held `in_fin` level from retriggering.
- `in_wr_en` in DRAIN or WAIT_CLR is ignored. Nothing is written.
- Arithmetic widths:
  - `wc` is DEPTH_LOG2+1 bits and saturates at 2^DEPTH_LOG2.
  - `rp` is DEPTH_LOG2 bits.
  - There is no wrap-around inside a segment.
- Buffer is a single-port-write, synchronous-read RAM inferred from a register array.

## Timing
- Reset values:
  - Outputs: `out_data`=0, `out_valid`=0, `out_last`=0, `out_len`=0, `busy`=0, `drop`=0.
  - Internal: state IDLE, `wc`=0, `rp`=0, `ovf`=0.
- Reset mid-operation: IDLE on the next edge. The buffered segment is discarded and no `drop` pulse is issued.
- Capture: a word on `in_wr_en` at edge N is stored at edge N. There is no throughput limit; one word per cycle is accepted.
- Latency: `in_fin` first sampled high at edge N gives `out_valid`=1 after edge N+2 (N+1 for the RAM read, N+2 for the output register).
- Handshake:
  - A transfer occurs when `out_valid` and `out_ready` are both 1.
  - `out_data`, `out_last` and `out_valid` hold while `out_ready`=0.
  - With `out_ready` held at 1, one word is output per cycle with no bubbles (a prefetch or skid register is required).
- `out_valid` drops on the edge after the `out_last` transfer.
- `busy` rises on the edge that enters DRAIN or WAIT_CLR. It falls on the edge that returns to IDLE.
- `drop` is high for exactly the one cycle after the edge that takes the transition.

## Configuration
- `TCP_LEN_CHECK_EN`, defined:
  - On `in_fin` in CAPTURE, compare `wc` against `(in_len+3)>>2`.
  - On mismatch, the segment is discarded exactly as for overflow: `drop` pulses and the block goes to WAIT_CLR with no output.
- `TCP_LEN_CHECK_EN`, undefined:
  - No comparison is made. The block drains `wc` words regardless of `in_len`.
  - `in_len` is only latched to `out_len`.

## Test plan
- Header-only segment:
  - Stimulus: 5 words 0x00501F90, 0x00000001, 0x00000002, 0x50120400, 0x00000000, then `in_fin` with checksum 0xBEEF and len 20.
  - Response: 5 words out, word 4 = 0xBEEF0000, `out_last` on word 4, `out_len`=20, first `out_valid` 2 cycles after `in_fin`.
- Data segment with backpressure:
  - Stimulus: 8 words (len 30), `out_ready` toggling 1,0,0,1.
  - Response: no word lost or duplicated, output held stable during stalls, word 4 upper half = checksum.
- Overflow, with DEPTH_LOG2=3:
  - Stimulus: 9 writes, then `in_fin`.
  - Response: one `drop` pulse, `out_valid` never asserted, IDLE after `in_fin` falls.
- Length mismatch, with `TCP_LEN_CHECK_EN` defined:
  - Stimulus: 6 words with len 28.
  - Response: `drop` pulse, no output. With the macro undefined: 6 words drained, `out_len`=28.
- `in_fin` held after drain:
  - Stimulus: `in_fin` kept high for 10 cycles after `out_last`.
  - Response: no second drain, `busy` stays 1 until `in_fin` falls, then IDLE.
- Reset mid-operation:
  - Stimulus: `reset` asserted at DRAIN word 2.
  - Response: next cycle `out_valid`=0, `busy`=0, `out_len`=0, and a new 5-word segment drains correctly.
